// File: rtl/psram_xfer_sched.sv
// -----------------------------------------------------------------------------
// psram_xfer_sched
//
// Scheduler in front of psram_core. Arbitrates between the config path
// (register-driven single transfers) and the bus path (memory transfers), then
// drives the single shared psram_core transfer port. After every transfer it
// inserts a programmable recovery gap before the next grant.
//
// Optional feature macro: PSRAM_SCHED_TIMEOUT_EN
//   Defined   : a transfer outstanding for TIMEOUT_CYC cycles is aborted, and
//               err_o pulses alongside the normal ack.
//   Undefined : no timeout counter is built, err_o is tied 0.
//
// Ports
//   clk_i         core clock
//   rst_i         synchronous active-high reset
//   cfg_req_i     config request level (held until cfg_ack_o)
//   cfg_wr_i      config direction, 1 = write
//   cfg_ack_o     one-cycle completion pulse to the config path
//   bus_req_i     bus request level (held until bus_ack_o)
//   bus_wr_i      bus direction, 1 = write
//   bus_ack_o     one-cycle completion pulse to the bus path
//   recy_i        recovery cycles after each transfer (sampled in DONE)
//   xfer_valid_o  transfer request to psram_core
//   xfer_rdwr_o   1 = read, 0 = write
//   xfer_sel_o    0 = bus path muxed to core, 1 = config path
//   xfer_ready_i  core completion pulse
//   busy_o        high in every state except IDLE
//   err_o         one-cycle timeout-abort pulse
//
// Handshake: xfer_valid_o rises one cycle after a grant and, together with
// xfer_sel_o/xfer_rdwr_o, stays stable until a cycle in which xfer_ready_i is
// sampled high while in XFER; the transfer completes on that edge. Requesters
// hold req high until they sample their ack pulse, and drop req on that edge.
// -----------------------------------------------------------------------------
module psram_xfer_sched #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_WIDTH   = 13
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cfg_req_i,
    input  logic       cfg_wr_i,
    output logic       cfg_ack_o,
    input  logic       bus_req_i,
    input  logic       bus_wr_i,
    output logic       bus_ack_o,
    input  logic [7:0] recy_i,
    output logic       xfer_valid_o,
    output logic       xfer_rdwr_o,
    output logic       xfer_sel_o,
    input  logic       xfer_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2,
        RECY = 2'd3
    } state_t;

    // The timeout counter must be able to hold TIMEOUT_CYC-1.
    if (TIMEOUT_CYC >= (2 ** CNT_WIDTH)) begin : g_cnt_width_check
        $error("psram_xfer_sched: CNT_WIDTH too small for TIMEOUT_CYC");
    end

    state_t     state_q;
    logic       valid_q;
    logic       rdwr_q;
    logic       sel_q;
    logic       cfg_ack_q;
    logic       bus_ack_q;
    logic       last_cfg_q;   // 1 = config path won the most recent grant
    logic [7:0] recy_cnt_q;
    logic       grant_cfg;

`ifdef PSRAM_SCHED_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYC - 1);
    logic [CNT_WIDTH-1:0] to_cnt_q;
    logic                 err_q;
`endif

    // Config wins when it is the only requester, or when both request and
    // the bus path was granted last (round-robin).
    always_comb begin
        grant_cfg = cfg_req_i & (~bus_req_i | ~last_cfg_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            rdwr_q     <= 1'b0;
            sel_q      <= 1'b0;
            cfg_ack_q  <= 1'b0;
            bus_ack_q  <= 1'b0;
            last_cfg_q <= 1'b0;
            recy_cnt_q <= 8'd0;
`ifdef PSRAM_SCHED_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // Acks (and err) are single-cycle pulses raised only on XFER->DONE.
            cfg_ack_q <= 1'b0;
            bus_ack_q <= 1'b0;
`ifdef PSRAM_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cfg_req_i || bus_req_i) begin
                        state_q    <= XFER;
                        valid_q    <= 1'b1;
                        sel_q      <= grant_cfg;
                        rdwr_q     <= grant_cfg ? ~cfg_wr_i : ~bus_wr_i;
                        last_cfg_q <= grant_cfg;
`ifdef PSRAM_SCHED_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                    end
                end
                XFER: begin
                    if (xfer_ready_i) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b0;
                        cfg_ack_q <= sel_q;
                        bus_ack_q <= ~sel_q;
                    end
`ifdef PSRAM_SCHED_TIMEOUT_EN
                    // Ready in the limit cycle is a normal completion.
                    else if (to_cnt_q == TO_LAST) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b0;
                        cfg_ack_q <= sel_q;
                        bus_ack_q <= ~sel_q;
                        err_q     <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // recy_i is captured here only; later changes are ignored.
                    recy_cnt_q <= recy_i;
                    state_q    <= (recy_i != 8'd0) ? RECY : IDLE;
                end
                RECY: begin
                    // Loaded with N, leaves after the cycle it reads 1: N cycles.
                    if (recy_cnt_q == 8'd1) begin
                        state_q <= IDLE;
                    end else begin
                        recy_cnt_q <= recy_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign xfer_valid_o = valid_q;
    assign xfer_rdwr_o  = rdwr_q;
    assign xfer_sel_o   = sel_q;
    assign cfg_ack_o    = cfg_ack_q;
    assign bus_ack_o    = bus_ack_q;
    assign busy_o       = (state_q != IDLE);

`ifdef PSRAM_SCHED_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_psram_xfer_sched.sv
// -----------------------------------------------------------------------------
// tb_psram_xfer_sched
//
// Self-checking bench for psram_xfer_sched. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled at that point and by a monitor on the
// falling edge. Grants ({sel, rdwr}) and acks ({cfg_ack, bus_ack, err}) are
// pushed as expectations when a request is driven and popped by the monitor
// when the DUT produces them. Build with PSRAM_SCHED_TIMEOUT_EN to also cover
// the timeout abort (TIMEOUT_CYC = 16).
// -----------------------------------------------------------------------------
module tb_psram_xfer_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cfg_req_i;
    logic       cfg_wr_i;
    logic       cfg_ack_o;
    logic       bus_req_i;
    logic       bus_wr_i;
    logic       bus_ack_o;
    logic [7:0] recy_i;
    logic       xfer_valid_o;
    logic       xfer_rdwr_o;
    logic       xfer_sel_o;
    logic       xfer_ready_i;
    logic       busy_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];      // expected grants {sel, rdwr}
    logic [2:0] exp_ack_q[$];  // expected completions {cfg_ack, bus_ack, err}

    typedef struct {
        logic       is_cfg;
        logic       wr;
        logic [7:0] recy;
        int         dly;        // XFER cycles before ready is raised
        logic [1:0] exp_grant;  // {sel, rdwr}
    } vec_t;

    vec_t vecs[12];

    psram_xfer_sched #(
        .TIMEOUT_CYC(16),
        .CNT_WIDTH  (13)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_req_i   (cfg_req_i),
        .cfg_wr_i    (cfg_wr_i),
        .cfg_ack_o   (cfg_ack_o),
        .bus_req_i   (bus_req_i),
        .bus_wr_i    (bus_wr_i),
        .bus_ack_o   (bus_ack_o),
        .recy_i      (recy_i),
        .xfer_valid_o(xfer_valid_o),
        .xfer_rdwr_o (xfer_rdwr_o),
        .xfer_sel_o  (xfer_sel_o),
        .xfer_ready_i(xfer_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        cfg_req_i    = 1'b0;
        cfg_wr_i     = 1'b0;
        bus_req_i    = 1'b0;
        bus_wr_i     = 1'b0;
        recy_i       = 8'd0;
        xfer_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic prev_valid = 1'b0;

    always @(negedge clk_i) begin
        logic [1:0] eg;
        logic [2:0] ea;
        if (xfer_valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got sel=%0b rdwr=%0b expected no grant at %0t",
                         xfer_sel_o, xfer_rdwr_o, $time);
            end else begin
                eg = exp_q.pop_front();
                check("grant_sel_rdwr", 32'({xfer_sel_o, xfer_rdwr_o}), 32'(eg));
            end
        end
        prev_valid = xfer_valid_o;
        if (cfg_ack_o || bus_ack_o || err_o) begin
            if (exp_ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got cfg=%0b bus=%0b err=%0b expected none at %0t",
                         cfg_ack_o, bus_ack_o, err_o, $time);
            end else begin
                ea = exp_ack_q.pop_front();
                check("ack_cfg_bus_err", 32'({cfg_ack_o, bus_ack_o, err_o}), 32'(ea));
            end
        end
    end

    // ---------------- driver for one table vector ----------------
    task automatic run_vec(input vec_t v);
        int gap;
        cfg_req_i = v.is_cfg;
        bus_req_i = ~v.is_cfg;
        cfg_wr_i  = v.wr;
        bus_wr_i  = v.wr;
        recy_i    = v.recy;
        exp_q.push_back(v.exp_grant);
        exp_ack_q.push_back(v.is_cfg ? 3'b100 : 3'b010);
        tick();  // grant edge
        check("vec_valid_after_grant", 32'(xfer_valid_o), 32'd1);
        check("vec_busy_in_xfer", 32'(busy_o), 32'd1);
        repeat (v.dly) tick();
        check("vec_outputs_held", 32'({xfer_valid_o, xfer_sel_o, xfer_rdwr_o}),
              32'({1'b1, v.exp_grant}));
        xfer_ready_i = 1'b1;
        tick();  // DONE
        xfer_ready_i = 1'b0;
        check("vec_ack_in_done", 32'({cfg_ack_o, bus_ack_o, xfer_valid_o}),
              32'({v.is_cfg, ~v.is_cfg, 1'b0}));
        cfg_req_i = 1'b0;
        bus_req_i = 1'b0;
        tick();
        gap = 0;
        while (busy_o && gap < 300) begin
            gap++;
            tick();
        end
        check("vec_recovery_gap", 32'(gap), 32'(v.recy));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;

        // Fixed vectors: {is_cfg, wr, recy, dly, {sel, rdwr}}
        vecs[0] = '{1'b1, 1'b1, 8'd0,   4, 2'b10};  // cfg write, ready in 5th XFER cycle
        vecs[1] = '{1'b0, 1'b0, 8'd0,   0, 2'b01};  // bus read, single XFER cycle
        vecs[2] = '{1'b0, 1'b1, 8'd2,   1, 2'b00};
        vecs[3] = '{1'b1, 1'b0, 8'd1,   2, 2'b11};
        vecs[4] = '{1'b0, 1'b0, 8'd3,   0, 2'b01};
        vecs[5] = '{1'b1, 1'b1, 8'd5,   6, 2'b10};
        vecs[6] = '{1'b0, 1'b1, 8'd255, 2, 2'b00};  // maximum recovery
        vecs[7] = '{1'b1, 1'b0, 8'd0,   3, 2'b11};
        for (int i = 8; i < 12; i++) begin
            vecs[i].is_cfg    = 1'($urandom_range(0, 1));
            vecs[i].wr        = 1'($urandom_range(0, 1));
            vecs[i].recy      = 8'($urandom_range(0, 6));
            vecs[i].dly       = int'($urandom_range(0, 5));
            vecs[i].exp_grant = {vecs[i].is_cfg, ~vecs[i].wr};
        end

        // Reset state
        do_reset();
        check("reset_outputs",
              32'({xfer_valid_o, xfer_sel_o, xfer_rdwr_o, cfg_ack_o, bus_ack_o, busy_o, err_o}),
              32'd0);

        // Table-driven single transfers
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Both requesting from reset: cfg, bus, cfg, bus
        do_reset();
        cfg_req_i = 1'b1;
        cfg_wr_i  = 1'b1;
        bus_req_i = 1'b1;
        bus_wr_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
            exp_ack_q.push_back((i % 2 == 0) ? 3'b100 : 3'b010);
        end
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!xfer_valid_o && n < 20) begin
                tick();
                n++;
            end
            check("rr_grant_seen", 32'(xfer_valid_o), 32'd1);
            check("rr_grant_sel", 32'(xfer_sel_o), 32'((i % 2) == 0));
            xfer_ready_i = 1'b1;
            tick();
            xfer_ready_i = 1'b0;
            check("rr_ack", 32'({cfg_ack_o, bus_ack_o}), (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i == 3) begin
                cfg_req_i = 1'b0;
                bus_req_i = 1'b0;
            end
        end
        tick();
        tick();
        check("rr_idle_after", 32'({busy_o, xfer_valid_o}), 32'd0);

        // Recovery gap with a config request raised during RECY
        bus_req_i = 1'b1;
        bus_wr_i  = 1'b0;
        recy_i    = 8'd3;
        exp_q.push_back(2'b01);
        exp_ack_q.push_back(3'b010);
        tick();
        xfer_ready_i = 1'b1;
        tick();
        xfer_ready_i = 1'b0;
        check("recy_bus_ack", 32'(bus_ack_o), 32'd1);
        bus_req_i = 1'b0;
        tick();  // RECY, 3 left
        check("recy_busy_1", 32'(busy_o), 32'd1);
        cfg_req_i    = 1'b1;
        cfg_wr_i     = 1'b0;
        recy_i       = 8'd7;   // must not shorten/extend the running gap
        xfer_ready_i = 1'b1;   // ignored outside XFER
        exp_q.push_back(2'b11);
        exp_ack_q.push_back(3'b100);
        tick();
        xfer_ready_i = 1'b0;
        check("recy_busy_2", 32'(busy_o), 32'd1);
        tick();
        check("recy_busy_3", 32'(busy_o), 32'd1);
        tick();
        check("recy_first_idle", 32'({busy_o, xfer_valid_o}), 32'd0);
        tick();
        check("recy_cfg_granted", 32'({xfer_valid_o, xfer_sel_o, xfer_rdwr_o}), 32'b111);
        xfer_ready_i = 1'b1;
        tick();
        xfer_ready_i = 1'b0;
        check("recy_cfg_ack", 32'(cfg_ack_o), 32'd1);
        cfg_req_i = 1'b0;
        tick();
        n = 0;
        while (busy_o && n < 300) begin
            n++;
            tick();
        end
        check("recy_sampled_at_done", 32'(n), 32'd7);

        // Ready pulsed while IDLE: nothing happens
        recy_i       = 8'd0;
        xfer_ready_i = 1'b1;
        tick();
        xfer_ready_i = 1'b0;
        tick();
        check("idle_ready_ignored", 32'({busy_o, xfer_valid_o, cfg_ack_o, bus_ack_o}), 32'd0);

        // Reset in the middle of a transfer
        bus_req_i = 1'b1;
        bus_wr_i  = 1'b1;
        exp_q.push_back(2'b00);
        tick();
        tick();
        check("midrst_in_xfer", 32'(xfer_valid_o), 32'd1);
        bus_req_i = 1'b0;
        rst_i     = 1'b1;
        tick();
        check("midrst_dropped", 32'({xfer_valid_o, busy_o, cfg_ack_o, bus_ack_o}), 32'd0);
        rst_i = 1'b0;
        tick();
        check("midrst_no_ack", 32'({busy_o, cfg_ack_o, bus_ack_o}), 32'd0);
        run_vec('{1'b1, 1'b1, 8'd2, 1, 2'b10});

`ifdef PSRAM_SCHED_TIMEOUT_EN
        // No ready: abort after 16 XFER cycles with err
        cfg_req_i = 1'b1;
        cfg_wr_i  = 1'b0;
        recy_i    = 8'd0;
        exp_q.push_back(2'b11);
        exp_ack_q.push_back(3'b101);
        tick();
        n = 0;
        while (xfer_valid_o && n < 100) begin
            n++;
            tick();
        end
        check("timeout_xfer_cycles", 32'(n), 32'd16);
        check("timeout_err_ack", 32'({cfg_ack_o, err_o}), 32'b11);
        cfg_req_i = 1'b0;
        tick();
        check("timeout_err_pulse", 32'({err_o, busy_o}), 32'd0);

        // Ready in the limit cycle: normal completion
        bus_req_i = 1'b1;
        bus_wr_i  = 1'b0;
        exp_q.push_back(2'b01);
        exp_ack_q.push_back(3'b010);
        tick();
        repeat (15) tick();
        check("limit_still_valid", 32'(xfer_valid_o), 32'd1);
        xfer_ready_i = 1'b1;
        tick();
        xfer_ready_i = 1'b0;
        check("limit_ready_no_err", 32'({bus_ack_o, err_o}), 32'b10);
        bus_req_i = 1'b0;
        tick();
`endif

        tick();
        tick();
        check("grant_queue_drained", 32'(exp_q.size()), 32'd0);
        check("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psram_xfer_sched.md
Name: psram_xfer_sched

Overview:
- Scheduler in front of psram_core: arbitrates between the APB config path (register-driven single transfers) and the AXI bus path (memory transfers), and sequences the one shared psram_core transfer port.
- Issues xfer_valid/xfer_rdwr/xfer_sel to the core, holds them until the core reports completion, then enforces the programmed recovery gap before the next grant.
- Sits between the register/AXI-FSM logic and psram_core, in the core clock domain.

Parameters:
TIMEOUT_CYC, 4096, cycles a granted transfer may stay outstanding before abort (used only with the optional feature)
CNT_WIDTH, 13, width of the timeout counter; must satisfy 2**CNT_WIDTH > TIMEOUT_CYC

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous, active-high reset
cfg_req_i  in  1  config-path request level; held until cfg_ack_o
cfg_wr_i  in  1  config request direction (1 = write); stable while cfg_req_i is high
cfg_ack_o  out  1  one-cycle completion pulse to the config path
bus_req_i  in  1  bus-path request level; held until bus_ack_o
bus_wr_i  in  1  bus request direction (1 = write); stable while bus_req_i is high
bus_ack_o  out  1  one-cycle completion pulse to the bus path
recy_i  in  8  recovery cycles inserted after each transfer (CTRL.RECY)
xfer_valid_o  out  1  transfer request to psram_core
xfer_rdwr_o  out  1  1 = read, 0 = write
xfer_sel_o  out  1  0 = bus data/address muxed to core, 1 = config data/address
xfer_ready_i  in  1  core completion, one-cycle pulse
busy_o  out  1  high in every state except IDLE
err_o  out  1  one-cycle pulse on timeout abort (tied 0 without the feature)

Behaviour:
- Reset (rst_i sampled high at a clock edge): state IDLE; all outputs 0; last-grant pointer = bus (config wins the first tie); recovery and timeout counters 0.
- Reset mid-transfer drops xfer_valid_o on the next edge. No ack is issued for the aborted transfer.
- States: IDLE, XFER, DONE, RECY.
- IDLE:
  - Only one of cfg_req_i/bus_req_i high: grant it.
  - Both high: round-robin; the requester not granted last wins.
  - On grant, the next cycle is XFER with xfer_valid_o = 1, xfer_sel_o = granted path, xfer_rdwr_o = ~wr of the granted path. Grant latency is 1 cycle.
  - The winner, direction and sel are registered at grant and remain frozen through DONE.
- XFER:
  - xfer_valid_o held high and the other outputs stable until xfer_ready_i = 1.
  - On xfer_ready_i: next cycle is DONE.
  - xfer_ready_i is ignored in every state other than XFER.
- DONE:
  - Exactly one cycle; xfer_valid_o = 0; the granted path's ack = 1.
  - Next state is RECY if recy_i != 0, otherwise IDLE.
- RECY:
  - Counter loads recy_i on entry and decrements each cycle; exit to IDLE when it reaches 1. Total gap = recy_i cycles.
  - recy_i is sampled only at DONE; changes during RECY have no effect.
- Requester contract: req is deasserted on the edge that samples ack high, so the req seen in IDLE after DONE is already low. A req that stays high is treated as a new request.
- Minimum back-to-back spacing: grant cycle, then XFER ≥ 1 cycle, then DONE 1 cycle, then RECY recy_i cycles.
- A request arriving during XFER/DONE/RECY waits; it is never dropped.
- Round-robin pointer updates only on grant.

Optional Feature:
- Macro: PSRAM_SCHED_TIMEOUT_EN.
- Defined:
  - Counter clears at grant and increments each XFER cycle.
  - If it reaches TIMEOUT_CYC with no xfer_ready_i: next cycle is DONE, with err_o = 1 in that DONE cycle and the ack pulsed as normal.
  - xfer_ready_i in the same cycle as the limit counts as normal completion; err_o stays 0.
- Undefined: no counter is built, err_o is constant 0, and XFER waits indefinitely.

Test Plan:
- Reset, then cfg_req_i=1, cfg_wr_i=1, recy_i=0 → cycle+1 xfer_valid_o=1, xfer_sel_o=1, xfer_rdwr_o=0; ready pulse at cycle 5 → cfg_ack_o at cycle 6, IDLE at cycle 7, busy_o low.
- cfg_req_i and bus_req_i asserted together from reset, both held, recy_i=0 → grant order cfg, bus, cfg, bus; each ack exactly once per transfer.
- recy_i=3, bus read → after bus_ack_o, busy_o stays high 3 more cycles; a cfg_req_i raised during RECY is granted on the first IDLE cycle.
- xfer_ready_i pulsed while IDLE or RECY → no state change, no ack.
- rst_i asserted during XFER → next cycle xfer_valid_o=0 and state IDLE; no ack; a subsequent request works normally.
- With PSRAM_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, no ready → DONE after 16 XFER cycles with err_o=1 and the matching ack=1; ready exactly at cycle 16 → err_o=0.
